mc_req_sched: RTL and testbench
===============================

Name: mc_req_sched

Overview:
- Shares the single memory-controller (MC) request/response port between NUM_REQ event-processing cores.
- Round-robin request arbitration with one registered output stage that honours mc_rq_stall.
- Requester index tagged into the top bits of rtnctl; responses demultiplexed back by that tag.
- Per-requester outstanding-read credit limit; idle indication for the sim-end/GVT logic.

Parameters:
NUM_REQ, 4, number of requesting cores (power of 2, ≥2)
ID_W, 2, log2(NUM_REQ); width of requester tag
MC_RTNCTL_WIDTH, 32, MC rtnctl width; low MC_RTNCTL_WIDTH-ID_W bits belong to requester
MAX_OUTSTANDING, 8, max in-flight reads per requester (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_vld  in  NUM_REQ  per-requester request valid, held until granted
req_cmd  in  3*NUM_REQ  MC command per requester (1=RD, 2=WR)
req_scmd  in  4*NUM_REQ  MC sub-command
req_vadr  in  48*NUM_REQ  virtual address
req_size  in  2*NUM_REQ  access size
req_rtnctl  in  MC_RTNCTL_WIDTH*NUM_REQ  requester rtnctl; top ID_W bits ignored
req_data  in  64*NUM_REQ  write data
req_gnt  out  NUM_REQ  one-hot combinational grant; transfer when req_vld[i]&req_gnt[i]
rsp_vld  out  NUM_REQ  one-hot response valid
rsp_cmd  out  3  response command (broadcast)
rsp_scmd  out  4  response sub-command (broadcast)
rsp_rtnctl  out  MC_RTNCTL_WIDTH  response rtnctl, top ID_W bits zeroed
rsp_data  out  64  response data (broadcast)
rsp_stall  in  NUM_REQ  per-requester response backpressure
mc_rq_vld/cmd/scmd/vadr/size/rtnctl/data  out  1/3/4/48/2/MC_RTNCTL_WIDTH/64  MC request, registered
mc_rq_flush  out  1  tied 0
mc_rq_stall  in  1  MC backpressure
mc_rs_vld/cmd/scmd/rtnctl/data  in  1/3/4/MC_RTNCTL_WIDTH/64  MC response
mc_rs_stall  out  1  response backpressure to MC
idle  out  1  no outstanding reads and output stage empty

Behaviour:
- Reset: mc_rq_vld=0, all mc_rq_* fields 0, RR pointer=0, all outstanding counters=0, idle=1; req_gnt and rsp_vld are 0 by construction.
- Eligibility: eligible[i] = req_vld[i] & (cmd≠RD | cnt[i]<MAX_OUTSTANDING).
- Output stage: one register slot. load_ok = !mc_rq_vld | !mc_rq_stall.
- Grant: only when load_ok; first eligible index at or after ptr, wrapping. At most one req_gnt bit is set.
- On grant of i: capture fields into the slot next cycle, with rtnctl = {i[ID_W-1:0], req_rtnctl_i[low bits]}. Set ptr=(i+1) mod NUM_REQ.
- Latency: grant in cycle N gives mc_rq_vld=1 in N+1.
- Slot hold: while mc_rq_vld & mc_rq_stall, all mc_rq_* fields hold stable. If !mc_rq_stall and nothing is granted, mc_rq_vld→0.
- Back-to-back issue at one request per cycle when the MC does not stall.
- Credits: cnt[i] += 1 at grant of a RD. cnt[i] -= 1 when mc_rs_vld & tag==i & !mc_rs_stall. Simultaneous inc and dec leaves cnt unchanged. WR does not consume credit.
- Response routing: tag = mc_rs_rtnctl top ID_W bits. rsp_vld[tag] = mc_rs_vld; all other rsp_vld bits 0. Fields pass through combinationally, zero latency.
- mc_rs_stall = mc_rs_vld & rsp_stall[tag]. Response held by MC until not stalled.
- Response with tag whose cnt=0: delivered anyway; counter saturates at 0 (no underflow). This is a sim-assert error.
- idle = !mc_rq_vld & all cnt==0.
- Reset mid-operation: slot and counters cleared asynchronously; in-flight MC responses arriving after reset are routed but do not underflow counters.

Decomposition:
- Shared package/global include holds MC command constants (MC_CMD_RD=3'd1, MC_CMD_WR=3'd2) and the tag-field position macro.
- Natural sub-module: rr_pick, a combinational round-robin priority picker (req vector + ptr → one-hot grant + index).
- Counters and output slot stay in the top block.

Test Plan:
- Single RD from req 2, no stall → req_gnt=4'b0100 in N; cycle N+1 mc_rq_vld=1, mc_rq_rtnctl top bits=2'd2; cnt[2]=1; idle=0.
- All 4 requesting continuously, no stall → grants 0,1,2,3,0 on consecutive cycles; one mc_rq_vld per cycle.
- mc_rq_stall high 5 cycles with slot full → req_gnt=0 and mc_rq_* stable throughout; issue resumes the cycle after stall drops.
- Req 1 issues 8 RDs with no responses (MAX_OUTSTANDING=8) → 9th RD not granted while req 0 is still granted; one response tagged 1 → req 1 granted next cycle.
- Response rtnctl=32'h8000_0055 with rsp_stall[2]=1 → rsp_vld=4'b0100, rsp_rtnctl=32'h0000_0055, mc_rs_stall=1; rsp_stall low → cnt[2] decrements.
- Simultaneous RD grant and response for req 3 → cnt[3] unchanged. Assert rst_n low mid-burst → mc_rq_vld=0 and idle=1 immediately.

Source files
------------

// File: rtl/mc_req_sched_pkg.sv
// Shared constants and types for the memory-controller request scheduler.
package mc_req_sched_pkg;

    // MC command encodings used by the scheduler.
    localparam logic [2:0] MC_CMD_RD = 3'd1;
    localparam logic [2:0] MC_CMD_WR = 3'd2;

    // Outstanding-read counters only need to reach 15.
    localparam int CNT_W = 4;

    // Bit position of the lowest tag bit inside an rtnctl word.
    function automatic int tag_lsb(input int rtnctl_w, input int id_w);
        return rtnctl_w - id_w;
    endfunction

    // Request fields that travel through the output slot unchanged.
    // rtnctl is kept separately because its width is a parameter.
    typedef struct packed {
        logic [2:0]  cmd;
        logic [3:0]  scmd;
        logic [47:0] vadr;
        logic [1:0]  size;
        logic [63:0] data;
    } mc_fields_t;

endpackage

// File: rtl/mc_req_sched_if.sv
// Bus bundle between the cores, the scheduler and the MC port.
// The master modport is the scheduler. The slave modport is the environment
// (the cores plus the memory controller).
interface mc_req_sched_if #(
    parameter int NUM_REQ         = 4,
    parameter int ID_W            = 2,
    parameter int MC_RTNCTL_WIDTH = 32
);
    // Core request side.
    logic [NUM_REQ-1:0]                      req_vld;
    logic [NUM_REQ-1:0][2:0]                 req_cmd;
    logic [NUM_REQ-1:0][3:0]                 req_scmd;
    logic [NUM_REQ-1:0][47:0]                req_vadr;
    logic [NUM_REQ-1:0][1:0]                 req_size;
    logic [NUM_REQ-1:0][MC_RTNCTL_WIDTH-1:0] req_rtnctl;
    logic [NUM_REQ-1:0][63:0]                req_data;
    logic [NUM_REQ-1:0]                      req_gnt;

    // Core response side.
    logic [NUM_REQ-1:0]                      rsp_vld;
    logic [2:0]                              rsp_cmd;
    logic [3:0]                              rsp_scmd;
    logic [MC_RTNCTL_WIDTH-1:0]              rsp_rtnctl;
    logic [63:0]                             rsp_data;
    logic [NUM_REQ-1:0]                      rsp_stall;

    // MC request port.
    logic                                    mc_rq_vld;
    logic [2:0]                              mc_rq_cmd;
    logic [3:0]                              mc_rq_scmd;
    logic [47:0]                             mc_rq_vadr;
    logic [1:0]                              mc_rq_size;
    logic [MC_RTNCTL_WIDTH-1:0]              mc_rq_rtnctl;
    logic [63:0]                             mc_rq_data;
    logic                                    mc_rq_flush;
    logic                                    mc_rq_stall;

    // MC response port.
    logic                                    mc_rs_vld;
    logic [2:0]                              mc_rs_cmd;
    logic [3:0]                              mc_rs_scmd;
    logic [MC_RTNCTL_WIDTH-1:0]              mc_rs_rtnctl;
    logic [63:0]                             mc_rs_data;
    logic                                    mc_rs_stall;

    // Quiescence flag for the sim-end / GVT logic.
    logic                                    idle;

    modport master (
        input  req_vld, req_cmd, req_scmd, req_vadr, req_size, req_rtnctl, req_data,
        output req_gnt,
        output rsp_vld, rsp_cmd, rsp_scmd, rsp_rtnctl, rsp_data,
        input  rsp_stall,
        output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
               mc_rq_rtnctl, mc_rq_data, mc_rq_flush,
        input  mc_rq_stall,
        input  mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data,
        output mc_rs_stall,
        output idle
    );

    modport slave (
        output req_vld, req_cmd, req_scmd, req_vadr, req_size, req_rtnctl, req_data,
        input  req_gnt,
        input  rsp_vld, rsp_cmd, rsp_scmd, rsp_rtnctl, rsp_data,
        output rsp_stall,
        input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
               mc_rq_rtnctl, mc_rq_data, mc_rq_flush,
        output mc_rq_stall,
        output mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data,
        input  mc_rs_stall,
        input  idle
    );
endinterface

// File: rtl/mc_req_sched_rr_pick.sv
// Combinational round-robin picker. Returns the first set request at or
// after ptr_i, wrapping at NUM_REQ, as both a one-hot vector and an index.
module mc_req_sched_rr_pick
    import mc_req_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] sel;
    logic            found;

    // Walk the requesters starting at ptr_i. NUM_REQ is a power of two, so
    // the ID_W-bit add wraps naturally.
    always_comb begin
        cand  = '0;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr_i + ID_W'(k);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign idx_o = sel;
    assign any_o = found;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign gnt_o[gi] = found & (sel == ID_W'(gi));
    end

endmodule

// File: rtl/mc_req_sched.sv
// Shares one MC request/response port between NUM_REQ cores. Requests are
// round-robin arbitrated into a single registered output slot. The requester
// index rides in the top rtnctl bits and is used to route responses back.
// Each core's outstanding reads are capped by a credit counter.
module mc_req_sched
    import mc_req_sched_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ID_W            = 2,
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mc_req_sched_if.master bus
);

    localparam int LOW_W = tag_lsb(MC_RTNCTL_WIDTH, ID_W);

    // Arbitration.
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               load_ok;
    logic [ID_W-1:0]    ptr_q, ptr_d;

    // Output slot.
    logic                       slot_vld_q, slot_vld_d;
    mc_fields_t                 fields_q, fields_d;
    logic [MC_RTNCTL_WIDTH-1:0] rtnctl_q, rtnctl_d;

    // Response side.
    logic [ID_W-1:0]    rs_tag;
    logic               rs_accept;
    logic [NUM_REQ-1:0] rsp_onehot;
    logic [NUM_REQ-1:0] cnt_zero;

    // The slot can take a new request when it is empty or is draining this cycle.
    assign load_ok  = !slot_vld_q | !bus.mc_rq_stall;
    assign pick_req = eligible & {NUM_REQ{load_ok}};

    mc_req_sched_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_i (pick_req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign bus.req_gnt = gnt;

    assign rs_tag    = bus.mc_rs_rtnctl[MC_RTNCTL_WIDTH-1 -: ID_W];
    assign rs_accept = bus.mc_rs_vld & !bus.mc_rs_stall;

    // Per-requester eligibility and outstanding-read credit counter.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [CNT_W-1:0] cnt_q;
        logic             inc;
        logic             dec;

        assign eligible[gi] = bus.req_vld[gi] &
                              ((bus.req_cmd[gi] != MC_CMD_RD) ||
                               (cnt_q < CNT_W'(MAX_OUTSTANDING)));
        assign inc          = gnt[gi] & (bus.req_cmd[gi] == MC_CMD_RD);
        // A stray response to an idle requester must not wrap the counter.
        assign dec          = rs_accept & (rs_tag == ID_W'(gi)) & (cnt_q != '0);
        assign cnt_zero[gi] = (cnt_q == '0);

        // Count reads out at grant and back at accepted response.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (inc && !dec) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (dec && !inc) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Next state of the slot and the round-robin pointer. A grant loads the
    // slot. An unstalled slot with no new grant empties. Otherwise it holds.
    always_comb begin
        slot_vld_d = slot_vld_q;
        fields_d   = fields_q;
        rtnctl_d   = rtnctl_q;
        ptr_d      = ptr_q;
        if (gnt_any) begin
            slot_vld_d    = 1'b1;
            fields_d.cmd  = bus.req_cmd[gnt_idx];
            fields_d.scmd = bus.req_scmd[gnt_idx];
            fields_d.vadr = bus.req_vadr[gnt_idx];
            fields_d.size = bus.req_size[gnt_idx];
            fields_d.data = bus.req_data[gnt_idx];
            rtnctl_d      = {gnt_idx, bus.req_rtnctl[gnt_idx][LOW_W-1:0]};
            ptr_d         = gnt_idx + 1'b1;
        end else if (load_ok) begin
            slot_vld_d = 1'b0;
        end
    end

    // Output slot and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld_q <= 1'b0;
            fields_q   <= '0;
            rtnctl_q   <= '0;
            ptr_q      <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            fields_q   <= fields_d;
            rtnctl_q   <= rtnctl_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.mc_rq_vld    = slot_vld_q;
    assign bus.mc_rq_cmd    = fields_q.cmd;
    assign bus.mc_rq_scmd   = fields_q.scmd;
    assign bus.mc_rq_vadr   = fields_q.vadr;
    assign bus.mc_rq_size   = fields_q.size;
    assign bus.mc_rq_data   = fields_q.data;
    assign bus.mc_rq_rtnctl = rtnctl_q;
    assign bus.mc_rq_flush  = 1'b0;

    // Steer the response valid to the tagged requester only.
    always_comb begin
        rsp_onehot = '0;
        if (bus.mc_rs_vld) begin
            rsp_onehot[rs_tag] = 1'b1;
        end
    end

    assign bus.rsp_vld     = rsp_onehot;
    assign bus.rsp_cmd     = bus.mc_rs_cmd;
    assign bus.rsp_scmd    = bus.mc_rs_scmd;
    assign bus.rsp_data    = bus.mc_rs_data;
    assign bus.rsp_rtnctl  = {{ID_W{1'b0}}, bus.mc_rs_rtnctl[LOW_W-1:0]};
    assign bus.mc_rs_stall = bus.mc_rs_vld & bus.rsp_stall[rs_tag];

    assign bus.idle = !slot_vld_q & (&cnt_zero);

    // A response for a requester with no reads outstanding is a protocol error.
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(rs_accept && cnt_zero[rs_tag]));

endmodule

// File: tb/tb_mc_req_sched.sv
module tb_mc_req_sched;
    import mc_req_sched_pkg::*;

    logic clk;
    logic rst_n;

    mc_req_sched_if #(.NUM_REQ(4), .ID_W(2), .MC_RTNCTL_WIDTH(32)) bus ();

    mc_req_sched #(
        .NUM_REQ         (4),
        .ID_W            (2),
        .MC_RTNCTL_WIDTH (32),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] rd;
        logic       stall;
        logic       rs_vld;
        logic [1:0] rs_tag;
        logic [3:0] rs_stall;
        logic [3:0] e_gnt;
        logic       e_rq_vld;
        logic [1:0] e_rq_tag;
        logic [3:0] e_rsp_vld;
        logic       e_mc_rs_stall;
        logic       e_idle;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected slot rtnctl for requester i: tag on top, low 30 bits of the
    // requester's own rtnctl (whose top bits are deliberately set to 1s).
    function automatic logic [31:0] exp_rtn(input int i);
        logic [1:0]  t;
        logic [31:0] own;
        t   = 2'(i);
        own = 32'hFFFF_0000 + 32'(i);
        return {t, own[29:0]};
    endfunction

    task automatic set_cmds(input logic [3:0] rd);
        for (int i = 0; i < 4; i++) bus.req_cmd[i] = rd[i] ? MC_CMD_RD : MC_CMD_WR;
    endtask

    task automatic clear_inputs();
        bus.req_vld     = '0;
        bus.rsp_stall   = '0;
        bus.mc_rq_stall = 1'b0;
        bus.mc_rs_vld   = 1'b0;
        bus.mc_rs_cmd   = 3'd0;
        bus.mc_rs_scmd  = 4'd0;
        bus.mc_rs_rtnctl = '0;
        bus.mc_rs_data  = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req_cmd[i]    = MC_CMD_WR;
            bus.req_scmd[i]   = 4'(i);
            bus.req_vadr[i]   = 48'h1000 + 48'(i);
            bus.req_size[i]   = 2'(i);
            bus.req_rtnctl[i] = 32'hFFFF_0000 + 32'(i);
            bus.req_data[i]   = 64'hD0 + 64'(i);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        //            vld     rd      st rsv tag  rss      gnt     rqv tag  rspv     mrs idle
        tbl[0]  = '{4'b0100, 4'b1111, 0, 0, 2'd0, 4'b0000, 4'b0100, 0, 2'd0, 4'b0000, 0, 1};
        tbl[1]  = '{4'b0000, 4'b1111, 0, 0, 2'd0, 4'b0000, 4'b0000, 1, 2'd2, 4'b0000, 0, 0};
        tbl[2]  = '{4'b0000, 4'b1111, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 2'd0, 4'b0000, 0, 0};
        tbl[3]  = '{4'b0000, 4'b1111, 0, 1, 2'd2, 4'b0100, 4'b0000, 0, 2'd0, 4'b0100, 1, 0};
        tbl[4]  = '{4'b0000, 4'b1111, 0, 1, 2'd2, 4'b1011, 4'b0000, 0, 2'd0, 4'b0100, 0, 0};
        tbl[5]  = '{4'b0000, 4'b1111, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 2'd0, 4'b0000, 0, 1};
        tbl[6]  = '{4'b1111, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b1000, 0, 2'd0, 4'b0000, 0, 1};
        tbl[7]  = '{4'b1111, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b0001, 1, 2'd3, 4'b0000, 0, 0};
        tbl[8]  = '{4'b1111, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b0010, 1, 2'd0, 4'b0000, 0, 0};
        tbl[9]  = '{4'b1111, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b0100, 1, 2'd1, 4'b0000, 0, 0};
        tbl[10] = '{4'b1111, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b1000, 1, 2'd2, 4'b0000, 0, 0};
        tbl[11] = '{4'b1111, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b0001, 1, 2'd3, 4'b0000, 0, 0};
        tbl[12] = '{4'b0000, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b0000, 1, 2'd0, 4'b0000, 0, 0};
        tbl[13] = '{4'b0000, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 2'd0, 4'b0000, 0, 1};

        // Reset state, sampled while reset is held.
        #3;
        chk("rst_rq_vld",   {63'd0, bus.mc_rq_vld}, 64'd0);
        chk("rst_rq_vadr",  {16'd0, bus.mc_rq_vadr}, 64'd0);
        chk("rst_rq_rtn",   {32'd0, bus.mc_rq_rtnctl}, 64'd0);
        chk("rst_idle",     {63'd0, bus.idle}, 64'd1);
        chk("rst_gnt",      {60'd0, bus.req_gnt}, 64'd0);
        chk("rst_rsp_vld",  {60'd0, bus.rsp_vld}, 64'd0);
        chk("rst_flush",    {63'd0, bus.mc_rq_flush}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: single read, response routing, round robin.
        for (int v = 0; v < 14; v++) begin
            bus.req_vld      = tbl[v].vld;
            set_cmds(tbl[v].rd);
            bus.mc_rq_stall  = tbl[v].stall;
            bus.mc_rs_vld    = tbl[v].rs_vld;
            bus.mc_rs_rtnctl = {tbl[v].rs_tag, 30'h55};
            bus.rsp_stall    = tbl[v].rs_stall;
            #2;
            $display("vec %0d gnt=%b rq_vld=%b rsp_vld=%b idle=%b",
                     v, bus.req_gnt, bus.mc_rq_vld, bus.rsp_vld, bus.idle);
            chk($sformatf("v%0d_gnt", v), {60'd0, bus.req_gnt}, {60'd0, tbl[v].e_gnt});
            chk($sformatf("v%0d_rq_vld", v), {63'd0, bus.mc_rq_vld}, {63'd0, tbl[v].e_rq_vld});
            if (tbl[v].e_rq_vld)
                chk($sformatf("v%0d_rq_rtn", v), {32'd0, bus.mc_rq_rtnctl},
                    {32'd0, exp_rtn(int'(tbl[v].e_rq_tag))});
            chk($sformatf("v%0d_rsp_vld", v), {60'd0, bus.rsp_vld}, {60'd0, tbl[v].e_rsp_vld});
            chk($sformatf("v%0d_rs_stall", v), {63'd0, bus.mc_rs_stall}, {63'd0, tbl[v].e_mc_rs_stall});
            chk($sformatf("v%0d_idle", v), {63'd0, bus.idle}, {63'd0, tbl[v].e_idle});
            if (tbl[v].rs_vld)
                chk($sformatf("v%0d_rsp_rtn", v), {32'd0, bus.rsp_rtnctl}, 64'h55);
            @(negedge clk);
        end

        // Slot holds for 5 stalled cycles, then issue resumes.
        do_reset();
        bus.req_vld = 4'b1111;
        #2;
        chk("st_first_gnt", {60'd0, bus.req_gnt}, 64'b0001);
        @(negedge clk);
        bus.mc_rq_stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            $display("stall cycle %0d gnt=%b rq_vadr=%0h", c, bus.req_gnt, bus.mc_rq_vadr);
            chk("st_gnt", {60'd0, bus.req_gnt}, 64'd0);
            chk("st_rq_vld", {63'd0, bus.mc_rq_vld}, 64'd1);
            chk("st_rq_vadr", {16'd0, bus.mc_rq_vadr}, 64'h1000);
            chk("st_rq_data", bus.mc_rq_data, 64'hD0);
            chk("st_rq_rtn", {32'd0, bus.mc_rq_rtnctl}, {32'd0, exp_rtn(0)});
            @(negedge clk);
        end
        bus.mc_rq_stall = 1'b0;
        #2;
        chk("st_resume_gnt", {60'd0, bus.req_gnt}, 64'b0010);
        @(negedge clk);
        bus.req_vld = '0;
        #2;
        chk("st_next_vadr", {16'd0, bus.mc_rq_vadr}, 64'h1001);
        chk("st_next_size", {62'd0, bus.mc_rq_size}, 64'd1);
        chk("st_next_scmd", {60'd0, bus.mc_rq_scmd}, 64'd1);
        chk("st_next_cmd", {61'd0, bus.mc_rq_cmd}, {61'd0, MC_CMD_WR});
        @(negedge clk);
        #2;
        chk("st_drained", {63'd0, bus.mc_rq_vld}, 64'd0);

        // Credit limit on requester 1.
        do_reset();
        bus.req_vld = 4'b0010;
        set_cmds(4'b0011);
        for (int k = 0; k < 8; k++) begin
            #2;
            $display("credit rd %0d gnt=%b", k, bus.req_gnt);
            chk($sformatf("cr_gnt%0d", k), {60'd0, bus.req_gnt}, 64'b0010);
            @(negedge clk);
        end
        bus.req_vld = 4'b0011;
        #2;
        chk("cr_limit_other", {60'd0, bus.req_gnt}, 64'b0001);
        @(negedge clk);
        bus.req_vld = 4'b0010;
        #2;
        chk("cr_limit_blocked", {60'd0, bus.req_gnt}, 64'd0);
        @(negedge clk);
        bus.mc_rs_vld    = 1'b1;
        bus.mc_rs_rtnctl = {2'd1, 30'h7};
        #2;
        chk("cr_rsp_same_cycle", {60'd0, bus.req_gnt}, 64'd0);
        chk("cr_rsp_vld", {60'd0, bus.rsp_vld}, 64'b0010);
        @(negedge clk);
        bus.mc_rs_vld = 1'b0;
        #2;
        chk("cr_regained", {60'd0, bus.req_gnt}, 64'b0010);
        @(negedge clk);
        bus.req_vld = '0;
        for (int k = 0; k < 9; k++) begin
            bus.mc_rs_vld    = 1'b1;
            bus.mc_rs_rtnctl = (k < 8) ? {2'd1, 30'h7} : {2'd0, 30'h7};
            #2;
            chk($sformatf("cr_drain_idle%0d", k), {63'd0, bus.idle}, 64'd0);
            @(negedge clk);
        end
        bus.mc_rs_vld = 1'b0;
        #2;
        chk("cr_all_returned_idle", {63'd0, bus.idle}, 64'd1);

        // Response routing and stall for requester 2.
        do_reset();
        bus.req_vld = 4'b0100;
        set_cmds(4'b0100);
        #2;
        chk("rr_gnt", {60'd0, bus.req_gnt}, 64'b0100);
        @(negedge clk);
        bus.req_vld = '0;
        @(negedge clk);
        bus.mc_rs_vld    = 1'b1;
        bus.mc_rs_rtnctl = 32'h8000_0055;
        bus.mc_rs_cmd    = 3'd2;
        bus.mc_rs_scmd   = 4'h5;
        bus.mc_rs_data   = 64'hCAFE_F00D_1234_5678;
        bus.rsp_stall    = 4'b0100;
        #2;
        $display("route rsp_vld=%b rsp_rtnctl=%h mc_rs_stall=%b", bus.rsp_vld, bus.rsp_rtnctl, bus.mc_rs_stall);
        chk("rr_rsp_vld", {60'd0, bus.rsp_vld}, 64'b0100);
        chk("rr_rsp_rtn", {32'd0, bus.rsp_rtnctl}, 64'h55);
        chk("rr_mc_rs_stall", {63'd0, bus.mc_rs_stall}, 64'd1);
        chk("rr_rsp_data", bus.rsp_data, 64'hCAFE_F00D_1234_5678);
        chk("rr_rsp_cmd", {61'd0, bus.rsp_cmd}, 64'd2);
        chk("rr_rsp_scmd", {60'd0, bus.rsp_scmd}, 64'h5);
        @(negedge clk);
        bus.rsp_stall = '0;
        #2;
        chk("rr_unstalled", {63'd0, bus.mc_rs_stall}, 64'd0);
        chk("rr_held_idle", {63'd0, bus.idle}, 64'd0);
        @(negedge clk);
        bus.mc_rs_vld = 1'b0;
        #2;
        chk("rr_dec_idle", {63'd0, bus.idle}, 64'd1);

        // Simultaneous read grant and response for requester 3.
        do_reset();
        bus.req_vld = 4'b1000;
        set_cmds(4'b1000);
        #2;
        chk("sim_gnt1", {60'd0, bus.req_gnt}, 64'b1000);
        @(negedge clk);
        bus.mc_rs_vld    = 1'b1;
        bus.mc_rs_rtnctl = {2'd3, 30'h9};
        #2;
        chk("sim_gnt2", {60'd0, bus.req_gnt}, 64'b1000);
        chk("sim_rsp_vld", {60'd0, bus.rsp_vld}, 64'b1000);
        @(negedge clk);
        bus.req_vld   = '0;
        bus.mc_rs_vld = 1'b0;
        @(negedge clk);
        #2;
        chk("sim_cnt_kept", {63'd0, bus.idle}, 64'd0);
        @(negedge clk);
        bus.mc_rs_vld = 1'b1;
        @(negedge clk);
        bus.mc_rs_vld = 1'b0;
        #2;
        chk("sim_cnt_zero", {63'd0, bus.idle}, 64'd1);

        // Asynchronous reset in the middle of a read burst.
        do_reset();
        bus.req_vld = 4'b1111;
        set_cmds(4'b1111);
        repeat (3) @(negedge clk);
        #1;
        chk("mid_busy", {63'd0, bus.idle}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rq_vld", {63'd0, bus.mc_rq_vld}, 64'd0);
        chk("mid_idle", {63'd0, bus.idle}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("mid_ptr_reset", {60'd0, bus.req_gnt}, 64'b0001);
        clear_inputs();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
